// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Pixel requests are issued LEAD cycles
// ahead of the registered sync/DE/colour outputs so a lookup can sit in between.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1600,
    parameter int unsigned H_FRONT  = 96,
    parameter int unsigned H_SYNC   = 24,
    parameter int unsigned H_BACK   = 80,
    parameter int unsigned V_ACTIVE = 900,
    parameter int unsigned V_FRONT  = 96,
    parameter int unsigned V_SYNC   = 1,
    parameter int unsigned V_BACK   = 3,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned LEAD     = 2,
    parameter int unsigned CW       = 8,
    parameter int unsigned XW       = 11,
    parameter int unsigned YW       = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [XW-1:0]   o_req_x,
    output logic [YW-1:0]   o_req_y,
    output logic            o_req_valid,
    input  logic [3*CW-1:0] i_color,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic [CW-1:0]   o_r,
    output logic [CW-1:0]   o_g,
    output logic [CW-1:0]   o_b,
    output logic            o_line_start,
    output logic            o_frame_start,
    output logic [31:0]     o_frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [XW-1:0] H_LAST      = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_SYNC_END  = XW'(H_SYNC);
    localparam logic [XW-1:0] H_ACT_START = XW'(H_SYNC + H_BACK);
    localparam logic [XW-1:0] H_ACT_END   = XW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [YW-1:0] V_LAST      = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_SYNC_END  = YW'(V_SYNC);
    localparam logic [YW-1:0] V_ACT_START = YW'(V_SYNC + V_BACK);
    localparam logic [YW-1:0] V_ACT_END   = YW'(V_SYNC + V_BACK + V_ACTIVE);

    if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
        LEAD == 0 || XW < $clog2(H_TOTAL) || YW < $clog2(V_TOTAL)) begin : g_bad_params
        $error("vga_timing_gen: zero-width region, LEAD=0 or counter width too small");
    end

    // Region flags carried down the delay line, not sync levels: blank is all zero.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic line;
        logic frame;
    } tap_t;

    function automatic logic h_active(input logic [XW-1:0] h);
        return (h >= H_ACT_START) && (h < H_ACT_END);
    endfunction

    function automatic logic v_active(input logic [YW-1:0] v);
        return (v >= V_ACT_START) && (v < V_ACT_END);
    endfunction

    logic [XW-1:0]   h_cnt_q, h_cnt_d;
    logic [YW-1:0]   v_cnt_q, v_cnt_d;
    logic [XW-1:0]   req_x_q, req_x_d;
    logic [YW-1:0]   req_y_q, req_y_d;
    logic            req_valid_q, req_valid_d;
    tap_t            dec, tap;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            de_q, de_d;
    logic [3*CW-1:0] color_q, color_d;
    logic            line_q, line_d;
    logic            frame_q, frame_d;
    logic [31:0]     frame_cnt_q, frame_cnt_d;
    logic            seen_frame_q, seen_frame_d;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        h_cnt_d = h_cnt_q + XW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + YW'(1);
        end
    end

    // Requests are computed from the next count so they stay aligned with the counters.
    always_comb begin
        req_valid_d = h_active(h_cnt_d) && v_active(v_cnt_d);
        req_x_d     = req_valid_d ? h_cnt_d - H_ACT_START : '0;
        req_y_d     = req_valid_d ? v_cnt_d - V_ACT_START : '0;
    end

    always_comb begin
        dec.hs    = (h_cnt_q < H_SYNC_END);
        dec.vs    = (v_cnt_q < V_SYNC_END);
        dec.act   = h_active(h_cnt_q) && v_active(v_cnt_q);
        dec.line  = (h_cnt_q == '0);
        dec.frame = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Decode, LEAD-1 delay stages and the output register add up to LEAD cycles.
    if (LEAD == 1) begin : g_no_delay
        assign tap = dec;
    end else begin : g_delay
        tap_t dly_q [LEAD-1];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int i = 0; i < int'(LEAD) - 1; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= dec;
                for (int i = 1; i < int'(LEAD) - 1; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign tap = dly_q[LEAD-2];
    end

    always_comb begin
        hsync_d      = tap.hs ? H_POL : !H_POL;
        vsync_d      = tap.vs ? V_POL : !V_POL;
        de_d         = tap.act;
        color_d      = tap.act ? i_color : '0;
        line_d       = tap.line;
        frame_d      = tap.frame;
        frame_cnt_d  = frame_cnt_q;
        seen_frame_d = seen_frame_q;
        // The first frame after reset is not a completed frame, so it only arms the count.
        if (tap.frame) begin
            if (seen_frame_q) frame_cnt_d = frame_cnt_q + 32'd1;
            seen_frame_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block order; the async reset clears all of it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            req_x_q      <= '0;
            req_y_q      <= '0;
            req_valid_q  <= 1'b0;
            hsync_q      <= !H_POL;
            vsync_q      <= !V_POL;
            de_q         <= 1'b0;
            color_q      <= '0;
            line_q       <= 1'b0;
            frame_q      <= 1'b0;
            frame_cnt_q  <= '0;
            seen_frame_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            req_x_q      <= req_x_d;
            req_y_q      <= req_y_d;
            req_valid_q  <= req_valid_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            color_q      <= color_d;
            line_q       <= line_d;
            frame_q      <= frame_d;
            frame_cnt_q  <= frame_cnt_d;
            seen_frame_q <= seen_frame_d;
        end
    end

    assign o_req_x       = req_x_q;
    assign o_req_y       = req_y_q;
    assign o_req_valid   = req_valid_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_de          = de_q;
    assign {o_r, o_g, o_b} = color_q;
    assign o_line_start  = line_q;
    assign o_frame_start = frame_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a configurable pixel-request lead. It replaces the fixed-mode generator. The block issues pixel coordinates `LEAD` cycles ahead of display so the upstream renderer or framebuffer can look up each pixel. It then emits registered sync, data-enable and colour, aligned to the monitor timing. It sits between the renderer/framebuffer and the DAC pins.

## Interface
Parameters:
- `H_ACTIVE`, default 1600: visible pixels per line
- `H_FRONT`, default 96: horizontal front porch, in pixels
- `H_SYNC`, default 24: horizontal sync width, in pixels
- `H_BACK`, default 80: horizontal back porch, in pixels
- `V_ACTIVE`, default 900: visible lines
- `V_FRONT`, default 96: vertical front porch, in lines
- `V_SYNC`, default 1: vertical sync width, in lines
- `V_BACK`, default 3: vertical back porch, in lines
- `H_POL`, default 0: asserted level of hsync
- `V_POL`, default 0: asserted level of vsync
- `LEAD`, default 2: cycles from request to displayed pixel; must be ≥1
- `CW`, default 8: bits per colour channel
- `XW`, default 11: width of x, must satisfy XW ≥ clog2(H_TOTAL)
- `YW`, default 10: width of y, must satisfy YW ≥ clog2(V_TOTAL)

Ports:
- `i_clk` in 1: pixel clock
- `i_rst` in 1: asynchronous, active-high reset
- `o_req_x` out XW: requested pixel column, 0..H_ACTIVE-1
- `o_req_y` out YW: requested pixel row, 0..V_ACTIVE-1
- `o_req_valid` out 1: request coordinates are inside the active area
- `i_color` in 3*CW: colour {R,G,B} for a request; sampled LEAD-1 cycles after that request
- `o_hsync` out 1: horizontal sync
- `o_vsync` out 1: vertical sync
- `o_de` out 1: output pixel is active
- `o_r` out CW: red channel
- `o_g` out CW: green channel
- `o_b` out CW: blue channel
- `o_line_start` out 1: one-cycle pulse at the first cycle of each line, output-aligned
- `o_frame_start` out 1: one-cycle pulse at the first cycle of each frame, output-aligned
- `o_frame_cnt` out 32: count of completed frames

## Operation
- H_TOTAL = sum of the four H_* widths; V_TOTAL = sum of the four V_* widths.
- Counter stage: h_cnt runs 0..H_TOTAL-1, v_cnt runs 0..V_TOTAL-1.
  - h_cnt wraps to 0 at H_TOTAL-1 and v_cnt increments on that wrap.
  - v_cnt wraps to 0 when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
- Region order within each axis:
  - SYNC: [0, S)
  - BACK: [S, S+B)
  - ACTIVE: [S+B, S+B+A)
  - FRONT: the remainder.
- Request outputs (o_req_*) are registers that move with the counters:
  - o_req_valid = h in ACTIVE and v in ACTIVE.
  - o_req_x = h_cnt − (H_SYNC+H_BACK) when valid, else 0.
  - o_req_y = v_cnt − (V_SYNC+V_BACK) when valid, else 0.
- Delay line, LEAD stages deep, carries {hsync region, vsync region, active, h==0, h==0&&v==0}.
- Output stage is registered:
  - o_hsync = H_POL when the delayed h is in SYNC, else !H_POL; o_vsync likewise with V_POL.
  - o_de = delayed active.
  - {o_r,o_g,o_b} = i_color when the delayed active is 1, else 0.
- o_frame_cnt increments by 1, wrapping at 2^32, in the same cycle o_frame_start asserts. The exception is the first frame after reset, where it stays 0.
- Degenerate parameters (any width = 0, or LEAD = 0) are unsupported; the block flags them with an elaboration-time assertion.

## Timing
- Reset values:
  - h_cnt = 0 and v_cnt = 0.
  - o_req_x/o_req_y/o_req_valid = 0.
  - Delay line cleared to blank, sync deasserted and no pulses.
  - o_hsync = !H_POL, o_vsync = !V_POL.
  - o_de, o_r, o_g, o_b, o_line_start, o_frame_start, o_frame_cnt = 0.
- Cycle 0 is the first clock edge after i_rst falls; counters are at (0,0) in the sync region.
- A request presented at cycle t appears on o_de/RGB at cycle t+LEAD. i_color is sampled at edge t+LEAD-1→t+LEAD, so LEAD=1 requires a combinational lookup.
- The first o_frame_start and o_line_start pulse occurs at cycle LEAD; after that they repeat every V_TOTAL·H_TOTAL and H_TOTAL cycles respectively.
- vsync edges coincide with the o_line_start cycle.
- Assertion of i_rst mid-frame takes effect immediately (async) on every output. The frame restarts from (0,0) with no partial-line artefacts after release.

## Test plan
- Small params (H 8/2/2/2, V 4/1/1/1, LEAD=2): reset release → o_line_start and o_frame_start high at cycle 2. o_hsync low over cycles 2–3 of each 14-cycle line. First o_de is at cycle 2+4+14·2 = 34.
- Request/colour alignment, same params, i_color = {x,y,x^y} mapped from the previous cycle's request: every o_de pixel shows the value for its coordinate. o_r = 0..7 across each active line; RGB = 0 whenever o_de = 0.
- Frame wrap: run 3 full frames (3·14·7 = 294 cycles) → o_frame_cnt steps 0→1→2 exactly at the o_frame_start pulses. o_req_valid is high for 8·4 = 32 cycles per frame.
- LEAD sweep 1, 2, 4 with the same stimulus → output waveforms are identical apart from a shift of LEAD cycles.
- Polarity: H_POL = 1, V_POL = 1 → syncs idle low and pulse high; vsync is high for exactly 14 cycles per frame.
- Reset mid-active line (at cycle 40): all outputs go to reset values in the same cycle. After release the sequence matches the first scenario from cycle 0, and o_frame_cnt = 0.
